// File: rtl/dram_portb_arbiter.sv
// Round-robin arbiter sharing data-RAM port B between two masters.
// Supports a bounded burst lock and returns one-cycle-latency responses.
module dram_portb_arbiter #(
  parameter int WORD_BITS = 12,
  parameter int MAX_HOLD  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_lock,
  input  logic [3:0]  m0_we,
  input  logic [29:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_lock,
  input  logic [3:0]  m1_we,
  input  logic [29:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic [3:0]  ram_web,
  output logic [29:0] ram_addrb,
  output logic [31:0] ram_dinb,
  input  logic [31:0] ram_doutb
);

  typedef enum logic [1:0] {OWN_NONE, OWN_M0, OWN_M1} owner_t;

  localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

  logic [1:0]  req;
  logic [1:0]  lock;
  logic [3:0]  we    [2];
  logic [29:0] addr  [2];
  logic [31:0] wdata [2];
  logic [1:0]  addr_ok;
  logic [1:0]  gnt;
  logic [1:0]  rvalid;
  logic [1:0]  err;
  logic [31:0] rdata [2];

  owner_t      lock_owner_reg, lock_owner_next;
  logic [7:0]  hold_cnt_reg, hold_cnt_next;
  logic        last_winner_reg, last_winner_next;
  logic        forced;
  logic        xfer;
  logic        win;
  logic        owner_valid;
  logic        owner_idx;

  assign req      = {m1_req, m0_req};
  assign lock     = {m1_lock, m0_lock};
  assign we[0]    = m0_we;
  assign we[1]    = m1_we;
  assign addr[0]  = m0_addr;
  assign addr[1]  = m1_addr;
  assign wdata[0] = m0_wdata;
  assign wdata[1] = m1_wdata;

  assign owner_valid = (lock_owner_reg != OWN_NONE);
  assign owner_idx   = (lock_owner_reg == OWN_M1);
  assign xfer        = |gnt;
  assign win         = gnt[1];

  // Grant: lone requester wins; under contention the lock owner keeps the
  // port until its hold budget is spent, otherwise strict alternation.
  always_comb begin
    gnt    = 2'b00;
    forced = 1'b0;
    if (rst_n) begin
      if (req == 2'b01) begin
        gnt = 2'b01;
      end else if (req == 2'b10) begin
        gnt = 2'b10;
      end else if (req == 2'b11) begin
        if (owner_valid) begin
          if (hold_cnt_reg < MAX_HOLD_C) begin
            gnt = owner_idx ? 2'b10 : 2'b01;
          end else begin
            forced = 1'b1;
            gnt    = owner_idx ? 2'b01 : 2'b10;
          end
        end else begin
          gnt = last_winner_reg ? 2'b01 : 2'b10;
        end
      end
    end
  end

  always_comb begin
    lock_owner_next  = lock_owner_reg;
    hold_cnt_next    = hold_cnt_reg;
    last_winner_next = last_winner_reg;
    if (owner_valid && !req[owner_idx]) begin
      lock_owner_next = OWN_NONE;
      hold_cnt_next   = 8'd0;
    end
    if (xfer) begin
      last_winner_next = win;
      if (forced) begin
        lock_owner_next = OWN_NONE;
        hold_cnt_next   = 8'd0;
      end else if (lock[win]) begin
        if (owner_valid && owner_idx == win) begin
          if (req[~win]) hold_cnt_next = hold_cnt_reg + 8'd1;
        end else begin
          // The transfer that takes ownership already counts against the budget.
          lock_owner_next = win ? OWN_M1 : OWN_M0;
          hold_cnt_next   = {7'd0, req[~win]};
        end
      end else begin
        if (owner_valid && owner_idx == win) lock_owner_next = OWN_NONE;
        hold_cnt_next = 8'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_owner_reg  <= OWN_NONE;
      hold_cnt_reg    <= 8'd0;
      last_winner_reg <= 1'b1;
    end else begin
      lock_owner_reg  <= lock_owner_next;
      hold_cnt_reg    <= hold_cnt_next;
      last_winner_reg <= last_winner_next;
    end
  end

  always_comb begin
    ram_web   = 4'b0000;
    ram_addrb = 30'd0;
    ram_dinb  = 32'd0;
    if (xfer) begin
      ram_addrb = addr[win];
      ram_dinb  = wdata[win];
      ram_web   = addr_ok[win] ? we[win] : 4'b0000;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_resp
      logic rvalid_reg;
      logic err_reg;
      logic rd_sel_reg;

      assign addr_ok[gi] = (addr[gi][29:WORD_BITS] == '0);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rvalid_reg <= 1'b0;
          err_reg    <= 1'b0;
          rd_sel_reg <= 1'b0;
        end else begin
          rvalid_reg <= gnt[gi];
          err_reg    <= gnt[gi] & ~addr_ok[gi];
          rd_sel_reg <= gnt[gi] & addr_ok[gi] & (we[gi] == 4'b0000);
        end
      end

      // RAM data arrives one cycle after the address, so it is steered, not registered.
      assign rvalid[gi] = rvalid_reg;
      assign err[gi]    = err_reg;
      assign rdata[gi]  = rd_sel_reg ? ram_doutb : 32'd0;
    end
  endgenerate

  assign m0_gnt    = gnt[0];
  assign m1_gnt    = gnt[1];
  assign m0_rvalid = rvalid[0];
  assign m1_rvalid = rvalid[1];
  assign m0_err    = err[0];
  assign m1_err    = err[1];
  assign m0_rdata  = rdata[0];
  assign m1_rdata  = rdata[1];

endmodule

// File: tb/tb_dram_portb_arbiter.sv
// Bench for dram_portb_arbiter: directed scenarios plus a randomized run
// against a behavioural arbitration model and a reference memory.
module tb_dram_portb_arbiter;
  localparam int WB = 12;
  localparam int MH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m0_req, m0_lock, m1_req, m1_lock;
  logic [3:0] m0_we, m1_we;
  logic [29:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [3:0] ram_web;
  logic [29:0] ram_addrb;
  logic [31:0] ram_dinb;
  logic [31:0] ram_doutb;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [4096];
  logic [31:0] ref_mem [4096];

  always #5 clk = ~clk;

  dram_portb_arbiter #(.WORD_BITS(WB), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .ram_web(ram_web), .ram_addrb(ram_addrb), .ram_dinb(ram_dinb), .ram_doutb(ram_doutb)
  );

  // Synchronous BRAM port B with byte enables and one-cycle read latency.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (ram_web[b]) mem[ram_addrb[11:0]][8*b +: 8] <= ram_dinb[8*b +: 8];
    ram_doutb <= mem[ram_addrb[11:0]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_req = 0; m0_lock = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_lock = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    m0_req = 1; m0_addr = 30'd4;
    @(posedge clk); #4;
    checks++; if (m0_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b expected 0", m0_gnt); end
    tick();
    rst_n = 1;
    #3;
    checks++; if ({m0_rvalid, m1_rvalid, m0_err, m1_err} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {m0_rvalid, m1_rvalid, m0_err, m1_err}); end
    checks++; if ({m0_rdata, m1_rdata} !== 64'd0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", {m0_rdata, m1_rdata}); end
    checks++; if (m0_gnt !== 1'b1) begin errors++; $display("FAIL first_gnt: got %b expected 1", m0_gnt); end
    tick();
    m0_req = 0;
    #3;
    checks++; if (m0_rvalid !== 1'b1 || m0_err !== 1'b0) begin errors++; $display("FAIL first_resp: got rvalid=%b err=%b expected 1 0", m0_rvalid, m0_err); end
    checks++; if (m0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL first_rdata: got %h expected deadbeef", m0_rdata); end
    checks++; if ({m1_rvalid, m1_err, m1_rdata} !== 34'd0) begin errors++; $display("FAIL m1_quiet: got %h expected 0", {m1_rvalid, m1_err, m1_rdata}); end
    $display("xfer m0 read word 4");
    tick();
  endtask

  task automatic test_round_robin();
    int exp_w, prev;
    logic [31:0] rd;
    do_reset();
    m0_addr = 30'd20; m1_addr = 30'd21;
    for (int k = 0; k < 7; k++) begin
      m0_req = (k < 6); m1_req = (k < 6);
      #3;
      exp_w = k % 2;
      if (k < 6) begin
        checks++;
        if (m0_gnt !== (exp_w == 0) || m1_gnt !== (exp_w == 1)) begin
          errors++; $display("FAIL rr_gnt[%0d]: got %b%b expected %b%b", k, m1_gnt, m0_gnt, exp_w == 1, exp_w == 0);
        end
        $display("xfer m%0d read cycle %0d", exp_w, k);
      end
      if (k > 0) begin
        prev = (k - 1) % 2;
        checks++;
        if ({m1_rvalid, m0_rvalid} !== (prev == 1 ? 2'b10 : 2'b01)) begin
          errors++; $display("FAIL rr_rvalid[%0d]: got %b%b expected m%0d", k, m1_rvalid, m0_rvalid, prev);
        end
        rd = (prev == 1) ? m1_rdata : m0_rdata;
        checks++;
        if (rd !== ref_mem[prev == 1 ? 21 : 20]) begin
          errors++; $display("FAIL rr_rdata[%0d]: got %h expected %h", k, rd, ref_mem[prev == 1 ? 21 : 20]);
        end
      end
      tick();
    end
  endtask

  task automatic test_byte_write();
    logic [31:0] exp_v;
    exp_v = (ref_mem[8] & 32'hFFFF00FF) | 32'h0000AB00;
    m1_req = 1; m1_we = 4'b0010; m1_addr = 30'd8; m1_wdata = 32'h0000AB00;
    #3;
    checks++; if (m1_gnt !== 1'b1 || ram_web !== 4'b0010 || ram_addrb !== 30'd8) begin errors++; $display("FAIL bw_drive: got gnt=%b web=%b addr=%h expected 1 0010 8", m1_gnt, ram_web, ram_addrb); end
    $display("xfer m1 write word 8 we=0010");
    tick();
    m1_we = 4'b0000; m1_wdata = 0;
    #3;
    checks++; if (m1_rvalid !== 1'b1 || m1_rdata !== 32'd0 || m1_err !== 1'b0) begin errors++; $display("FAIL bw_wresp: got %b %h %b expected 1 0 0", m1_rvalid, m1_rdata, m1_err); end
    $display("xfer m1 read word 8");
    tick();
    idle();
    #3;
    checks++; if (m1_rdata !== exp_v) begin errors++; $display("FAIL bw_rdata: got %h expected %h", m1_rdata, exp_v); end
    ref_mem[8] = exp_v;
    tick();
  endtask

  task automatic test_out_of_range();
    m0_req = 1; m0_we = 4'hF; m0_addr = 30'h0400_0000; m0_wdata = 32'hFFFFFFFF;
    #3;
    checks++; if (m0_gnt !== 1'b1 || ram_web !== 4'b0000) begin errors++; $display("FAIL oor_web: got gnt=%b web=%b expected 1 0000", m0_gnt, ram_web); end
    $display("xfer m0 write out of range");
    tick();
    m0_we = 0; m0_addr = 30'd0; m0_wdata = 0;
    #3;
    checks++; if (m0_rvalid !== 1'b1 || m0_err !== 1'b1 || m0_rdata !== 32'd0) begin errors++; $display("FAIL oor_resp: got %b %b %h expected 1 1 0", m0_rvalid, m0_err, m0_rdata); end
    $display("xfer m0 read word 0");
    tick();
    idle();
    #3;
    checks++; if (m0_rdata !== ref_mem[0] || m0_err !== 1'b0) begin errors++; $display("FAIL oor_unchanged: got %h err=%b expected %h 0", m0_rdata, m0_err, ref_mem[0]); end
    tick();
  endtask

  task automatic test_lock_rotation();
    int exp_w [8] = '{0, 0, 0, 0, 1, 0, 1, 0};
    do_reset();
    m0_addr = 30'd3; m1_addr = 30'd7;
    for (int k = 0; k < 8; k++) begin
      m0_req  = (k != 6);
      m0_lock = (k < 6);
      m1_req  = 1;
      #3;
      checks++;
      if (m0_gnt !== (exp_w[k] == 0) || m1_gnt !== (exp_w[k] == 1)) begin
        errors++; $display("FAIL lock_gnt[%0d]: got %b%b expected m%0d", k, m1_gnt, m0_gnt, exp_w[k]);
      end
      $display("xfer m%0d lock cycle %0d", exp_w[k], k);
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_reset_mid_burst();
    idle();
    m1_req = 1; m1_addr = 30'd5;
    #3;
    $display("xfer m1 read word 5");
    tick();
    idle();
    checks++; if (m1_rvalid !== 1'b1) begin errors++; $display("FAIL mid_pre: got %b expected 1", m1_rvalid); end
    rst_n = 0;
    #1;
    checks++; if (m1_rvalid !== 1'b0 || m1_rdata !== 32'd0) begin errors++; $display("FAIL mid_clear: got %b %h expected 0 0", m1_rvalid, m1_rdata); end
    tick();
    rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      #3;
      checks++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin errors++; $display("FAIL mid_after[%0d]: got %b%b expected 00", k, m1_rvalid, m0_rvalid); end
      tick();
    end
  endtask

  task automatic test_random();
    bit r [2], lk [2], waiting [2];
    logic [3:0] rwe [2];
    logic [29:0] radr [2];
    logic [31:0] rwd [2];
    bit pv [2], pe [2];
    logic [31:0] pd [2];
    int last, owner, hold, w;
    bit forced, ok;
    logic [31:0] got_d;
    do_reset();
    last = 1; owner = -1; hold = 0;
    for (int i = 0; i < 2; i++) begin waiting[i] = 0; pv[i] = 0; pe[i] = 0; pd[i] = 0; end
    for (int cyc = 0; cyc < 300; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        if (!waiting[i]) begin
          r[i]    = ($urandom_range(0, 3) != 0);
          lk[i]   = $urandom_range(0, 1) == 1;
          rwe[i]  = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
          radr[i] = ($urandom_range(0, 9) == 0) ? (30'($urandom) | 30'h1000) : 30'($urandom_range(0, 31));
          rwd[i]  = $urandom;
        end
      end
      m0_req = r[0]; m0_lock = lk[0]; m0_we = rwe[0]; m0_addr = radr[0]; m0_wdata = rwd[0];
      m1_req = r[1]; m1_lock = lk[1]; m1_we = rwe[1]; m1_addr = radr[1]; m1_wdata = rwd[1];
      #3;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if ((i == 0 ? m0_rvalid : m1_rvalid) !== pv[i]) begin
          errors++; $display("FAIL rnd_rvalid m%0d cyc %0d: got %b expected %b", i, cyc, i == 0 ? m0_rvalid : m1_rvalid, pv[i]);
        end
        if (pv[i]) begin
          got_d = (i == 0) ? m0_rdata : m1_rdata;
          checks++;
          if ((i == 0 ? m0_err : m1_err) !== pe[i] || got_d !== pd[i]) begin
            errors++; $display("FAIL rnd_resp m%0d cyc %0d: got err=%b data=%h expected err=%b data=%h", i, cyc, i == 0 ? m0_err : m1_err, got_d, pe[i], pd[i]);
          end
        end
      end
      // Arbitration rules, stated directly.
      forced = 0;
      if (r[0] && !r[1]) w = 0;
      else if (r[1] && !r[0]) w = 1;
      else if (!r[0] && !r[1]) w = -1;
      else if (owner >= 0 && hold < MH) w = owner;
      else if (owner >= 0) begin w = 1 - owner; forced = 1; end
      else w = 1 - last;
      checks++;
      if (m0_gnt !== (w == 0) || m1_gnt !== (w == 1)) begin
        errors++; $display("FAIL rnd_gnt cyc %0d: got %b%b expected winner %0d", cyc, m1_gnt, m0_gnt, w);
      end
      ok = (w >= 0) && (radr[w < 0 ? 0 : w] < 30'd4096);
      checks++;
      if (w < 0) begin
        if ({ram_web, ram_addrb, ram_dinb} !== 66'd0) begin errors++; $display("FAIL rnd_idle_ram cyc %0d: got %h expected 0", cyc, {ram_web, ram_addrb, ram_dinb}); end
      end else if (ram_web !== (ok ? rwe[w] : 4'd0) || ram_addrb !== radr[w] || ram_dinb !== rwd[w]) begin
        errors++; $display("FAIL rnd_ram cyc %0d: got web=%h addr=%h din=%h expected web=%h addr=%h din=%h", cyc, ram_web, ram_addrb, ram_dinb, ok ? rwe[w] : 4'd0, radr[w], rwd[w]);
      end
      for (int i = 0; i < 2; i++) begin
        pv[i] = (w == i);
        pe[i] = (w == i) && !ok;
        pd[i] = ((w == i) && ok && rwe[i] == 0) ? ref_mem[radr[i][11:0]] : 32'd0;
      end
      if (w >= 0 && ok)
        for (int b = 0; b < 4; b++)
          if (rwe[w][b]) ref_mem[radr[w][11:0]][8*b +: 8] = rwd[w][8*b +: 8];
      if (w >= 0) $display("xfer m%0d addr=%h we=%h lock=%0d ok=%0d", w, radr[w], rwe[w], lk[w], ok);
      // Lock bookkeeping for the next cycle.
      if (owner >= 0 && !r[owner]) begin owner = -1; hold = 0; end
      if (w >= 0) begin
        last = w;
        if (forced) begin owner = -1; hold = 0; end
        else if (lk[w]) begin
          if (owner == w) begin if (r[1 - w]) hold++; end
          else begin owner = w; hold = r[1 - w] ? 1 : 0; end
        end else begin
          if (owner == w) owner = -1;
          hold = 0;
        end
      end
      for (int i = 0; i < 2; i++) waiting[i] = r[i] && (w != i);
      tick();
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0101;
      ref_mem[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0101;
    end
    mem[4] = 32'hDEADBEEF;
    ref_mem[4] = 32'hDEADBEEF;
    idle();
    test_reset();
    test_round_robin();
    test_byte_write();
    test_out_of_range();
    test_lock_rotation();
    test_reset_mid_burst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
